// File: rtl/temperature_light_power_pkg.sv
// Shared widths, parameter defaults and compare modes
// for the temperature/light/power controller.
package temperature_light_power_pkg;

  localparam int TEMP_W  = 8;
  localparam int LIGHT_W = 8;
  localparam int POWER_W = 9;
  localparam int CMP_W   = 9;

  localparam int TEMP_LOW_DEF      = 18;
  localparam int TEMP_HIGH_DEF     = 28;
  localparam int TEMP_HYST_DEF     = 2;
  localparam int LIGHT_DARK_DEF    = 64;
  localparam int LIGHT_HYST_DEF    = 8;
  localparam int POWER_LIMIT_DEF   = 300;
  localparam int ALARM_PERSIST_DEF = 4;

  typedef enum logic {
    CMP_BELOW = 1'b0,
    CMP_ABOVE = 1'b1
  } cmp_mode_e;

endpackage

// File: rtl/tlpc_hyst_cmp.sv
// Set/clear hysteresis flag; BELOW sets under SET_TH and clears
// at/above CLR_TH, ABOVE sets over SET_TH and clears at/below CLR_TH.
module tlpc_hyst_cmp
  import temperature_light_power_pkg::*;
#(
  parameter cmp_mode_e        MODE   = CMP_BELOW,
  parameter logic [CMP_W-1:0] SET_TH = '0,
  parameter logic [CMP_W-1:0] CLR_TH = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMP_W-1:0] val_i,
  output logic             flag_o
);

  logic flag_d, flag_q;

  always_comb begin
    flag_d = flag_q;
    if (MODE == CMP_BELOW) begin
      if (val_i < SET_TH)
        flag_d = 1'b1;
      else if (val_i >= CLR_TH)
        flag_d = 1'b0;
    end else begin
      if (val_i > SET_TH)
        flag_d = 1'b1;
      else if (val_i <= CLR_TH)
        flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/temperature_light_power_controller.sv
// Heater/cooler/lamp hysteresis control with over-power load shedding.
// Define ALARM_LATCH_EN to hold the alarm until reset.
module temperature_light_power_controller
  import temperature_light_power_pkg::*;
#(
  parameter int TEMP_LOW      = TEMP_LOW_DEF,
  parameter int TEMP_HIGH     = TEMP_HIGH_DEF,
  parameter int TEMP_HYST     = TEMP_HYST_DEF,
  parameter int LIGHT_DARK    = LIGHT_DARK_DEF,
  parameter int LIGHT_HYST    = LIGHT_HYST_DEF,
  parameter int POWER_LIMIT   = POWER_LIMIT_DEF,
  parameter int ALARM_PERSIST = ALARM_PERSIST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TEMP_W-1:0]  temperature_sensor,
  input  logic [LIGHT_W-1:0] light_sensor,
  input  logic [POWER_W-1:0] power_monitor,
  output logic               heater,
  output logic               cooler,
  output logic               light,
  output logic               alarm
);

  localparam int CW = $clog2(ALARM_PERSIST + 1);

  localparam logic [CMP_W-1:0] HEAT_SET = CMP_W'(TEMP_LOW);
  localparam logic [CMP_W-1:0] HEAT_CLR = CMP_W'(TEMP_LOW + TEMP_HYST);
  localparam logic [CMP_W-1:0] COOL_SET = CMP_W'(TEMP_HIGH);
  localparam logic [CMP_W-1:0] COOL_CLR = CMP_W'(TEMP_HIGH - TEMP_HYST);
  localparam logic [CMP_W-1:0] LITE_SET = CMP_W'(LIGHT_DARK);
  localparam logic [CMP_W-1:0] LITE_CLR = CMP_W'(LIGHT_DARK + LIGHT_HYST);
  localparam logic [POWER_W-1:0] PWR_LIM = POWER_W'(POWER_LIMIT);
  localparam logic [CW-1:0]      CNT_MAX = CW'(ALARM_PERSIST);

  logic [CMP_W-1:0] temp_ext, lite_ext;
  logic heat_st, cool_st, lite_st;
  logic over;
  logic [CW-1:0] cnt_d, cnt_q;
  logic alarm_d, alarm_q;

  assign temp_ext = {1'b0, temperature_sensor};
  assign lite_ext = {1'b0, light_sensor};

  tlpc_hyst_cmp #(
    .MODE   (CMP_BELOW),
    .SET_TH (HEAT_SET),
    .CLR_TH (HEAT_CLR)
  ) u_heat (
    .clk    (clk),
    .rst_n  (rst),
    .val_i  (temp_ext),
    .flag_o (heat_st)
  );

  tlpc_hyst_cmp #(
    .MODE   (CMP_ABOVE),
    .SET_TH (COOL_SET),
    .CLR_TH (COOL_CLR)
  ) u_cool (
    .clk    (clk),
    .rst_n  (rst),
    .val_i  (temp_ext),
    .flag_o (cool_st)
  );

  tlpc_hyst_cmp #(
    .MODE   (CMP_BELOW),
    .SET_TH (LITE_SET),
    .CLR_TH (LITE_CLR)
  ) u_lite (
    .clk    (clk),
    .rst_n  (rst),
    .val_i  (lite_ext),
    .flag_o (lite_st)
  );

  assign over = (power_monitor > PWR_LIM);

  always_comb begin
    cnt_d = '0;
    if (over)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
`ifdef ALARM_LATCH_EN
    alarm_d = alarm_q | (cnt_d == CNT_MAX);
`else
    alarm_d = (cnt_d == CNT_MAX);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  // Hysteresis states keep tracking under alarm; only the outputs shed.
  assign heater = heat_st & ~alarm_q;
  assign cooler = cool_st & ~alarm_q;
  assign light  = lite_st;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_temperature_light_power_controller.sv
// Directed bench for temperature_light_power_controller.
// Build with ALARM_LATCH_EN defined to exercise the latching alarm.
module tb_temperature_light_power_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] temperature_sensor = '0;
  logic [7:0] light_sensor = '0;
  logic [8:0] power_monitor = '0;
  logic       heater, cooler, light, alarm;

  int total = 0;
  int bad   = 0;

  temperature_light_power_controller dut (
    .clk                (clk),
    .rst                (rst),
    .temperature_sensor (temperature_sensor),
    .light_sensor       (light_sensor),
    .power_monitor      (power_monitor),
    .heater             (heater),
    .cooler             (cooler),
    .light              (light),
    .alarm              (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic h, input logic c,
                      input logic l, input logic a);
    chk({tag, ".heater"}, heater, h);
    chk({tag, ".cooler"}, cooler, c);
    chk({tag, ".light"},  light,  l);
    chk({tag, ".alarm"},  alarm,  a);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk4("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk4("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    step();
    chk4("cold_dark", 1'b1, 1'b0, 1'b1, 1'b0);

    temperature_sensor = 8'd85;
    step();
    chk("hot.heater", heater, 1'b0);
    chk("hot.cooler", cooler, 1'b1);
    temperature_sensor = 8'd27;
    step();
    chk("t27.cooler", cooler, 1'b1);
    temperature_sensor = 8'd26;
    step();
    chk("t26.cooler", cooler, 1'b0);
    temperature_sensor = 8'd85;
    step();
    chk("t85.cooler", cooler, 1'b1);

    light_sensor = 8'd51;
    step();
    chk("l51.light", light, 1'b1);
    light_sensor = 8'd70;
    step();
    chk("l70.light", light, 1'b1);
    light_sensor = 8'd72;
    step();
    chk("l72.light", light, 1'b0);
    light_sensor = 8'd51;
    step();
    chk("l51b.light", light, 1'b1);

    power_monitor = 9'd321;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("ovr_pre.alarm", alarm, 1'b0);
      chk("ovr_pre.cooler", cooler, 1'b1);
    end
    step();
    chk4("ovr4", 1'b0, 1'b0, 1'b1, 1'b1);

    power_monitor = 9'd300;
    step();
`ifdef ALARM_LATCH_EN
    chk("p300.alarm", alarm, 1'b1);
    chk("p300.cooler", cooler, 1'b0);
    power_monitor = 9'd100;
    step();
    chk("p100.alarm", alarm, 1'b1);
    chk("p100.cooler", cooler, 1'b0);
`else
    chk("p300.alarm", alarm, 1'b0);
    chk("p300.cooler", cooler, 1'b1);
`endif

    pulse_reset();
    step();
    chk4("post_rst", 1'b0, 1'b1, 1'b1, 1'b0);

    power_monitor = 9'd321;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("gap_a.alarm", alarm, 1'b0);
    end
    power_monitor = 9'd300;
    step();
    chk("gap_eq.alarm", alarm, 1'b0);
    power_monitor = 9'd321;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("gap_b.alarm", alarm, 1'b0);
      chk("gap_b.cooler", cooler, 1'b1);
    end

    pulse_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("midcnt.alarm", alarm, 1'b0);
    end
    step();
    chk("midcnt4.alarm", alarm, 1'b1);
    chk("midcnt4.cooler", cooler, 1'b0);

    power_monitor = 9'd300;
    step();
`ifdef ALARM_LATCH_EN
    chk("end.alarm", alarm, 1'b1);
`else
    chk("end.alarm", alarm, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
